// File: rtl/bsrk_i2c_calc_top.sv
// bsrk_i2c_calc_top: I2C target fronting an 8-bit calculator register file
// Ports:
//   clk     system clock (>= 16x SCL)
//   rst_n   synchronous active-low reset
//   ena     harness enable (ignored)
//   ui_in   [0] selects result byte on uo_out (0 = RES[7:0], 1 = RES[15:8])
//   uo_out  registered selected result byte
//   uio_in  [0] SDA in, [1] SCL in
//   uio_out constant 0 (SDA is open-drain through uio_oe)
//   uio_oe  [0] = 1 pulls SDA low
module bsrk_i2c_calc_top #(
  parameter logic [6:0] I2C_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [3:0] {IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WDATA, ACK_W, RDATA, MACK} state_t;
  state_t state_q, state_d;
  logic [2:0] sda_q, scl_q;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, ptr_q, ptr_d, a_q, a_d, b_q, b_d, uo_q, rd;
  logic [2:0] op_q, op_d;
  logic oe_q, oe_d;
  logic [15:0] res;
  logic sda, scl, scl_rise, scl_fall, start, stop, unused_ok;
  assign unused_ok = &{ena, ui_in[7:1], uio_in[7:2]};
  // [1] is the synchronised level, [2] the previous synchronised level
  assign sda = sda_q[1];
  assign scl = scl_q[1];
  assign scl_rise = scl & ~scl_q[2];
  assign scl_fall = ~scl & scl_q[2];
  assign start = scl & scl_q[2] & sda_q[2] & ~sda;
  assign stop = scl & scl_q[2] & ~sda_q[2] & sda;
  assign uo_out = uo_q;
  assign uio_out = 8'h00;
  assign uio_oe = {7'b0, oe_q};
  always_comb begin
    case (op_q)
      3'd0: res = {8'b0, a_q} + {8'b0, b_q};
      3'd1: res = {8'b0, a_q} - {8'b0, b_q};
      3'd2: res = {8'b0, a_q} * {8'b0, b_q};
      3'd3: res = {8'b0, a_q & b_q};
      3'd4: res = {8'b0, a_q | b_q};
      3'd5: res = {8'b0, a_q ^ b_q};
      3'd6: res = {8'b0, a_q} << b_q[3:0];
      default: res = {8'b0, a_q >> b_q[2:0]};
    endcase
  end
  always_comb
    rd = ptr_q[2:0] == 3'd0 ? a_q :
         ptr_q[2:0] == 3'd1 ? b_q :
         ptr_q[2:0] == 3'd2 ? {5'b0, op_q} :
         ptr_q[2:0] == 3'd3 ? res[7:0] :
         ptr_q[2:0] == 3'd4 ? res[15:8] : 8'h00;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    oe_d = oe_q;
    ptr_d = ptr_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    case (state_q)
      IDLE: ;
      ADDR, PTR, WDATA: begin
        if (scl_rise) begin
          sh_d = {sh_q[6:0], sda};
          cnt_d = cnt_q + 4'd1;
        end else if (scl_fall && cnt_q == 4'd8) begin
          cnt_d = '0;
          oe_d = 1'b1;
          if (state_q == ADDR) begin
            oe_d = sh_q[7:1] == I2C_ADDR;
            state_d = sh_q[7:1] == I2C_ADDR ? ACK_ADDR : IDLE;
          end else if (state_q == PTR) begin
            ptr_d = sh_q;
            state_d = ACK_PTR;
          end else begin
            a_d = ptr_q[2:0] == 3'd0 ? sh_q : a_q;
            b_d = ptr_q[2:0] == 3'd1 ? sh_q : b_q;
            op_d = ptr_q[2:0] == 3'd2 ? sh_q[2:0] : op_q;
            ptr_d = ptr_q + 8'd1;
            state_d = ACK_W;
          end
        end
      end
      // sh_q still holds the address byte, so bit 0 is R/W
      ACK_ADDR: if (scl_fall) begin
        state_d = sh_q[0] ? RDATA : PTR;
        sh_d = sh_q[0] ? rd : sh_q;
        oe_d = sh_q[0] & ~rd[7];
      end
      ACK_PTR, ACK_W: if (scl_fall) begin
        state_d = WDATA;
        oe_d = 1'b0;
      end
      RDATA: begin
        if (scl_rise) cnt_d = cnt_q + 4'd1;
        else if (scl_fall && cnt_q == 4'd8) begin
          oe_d = 1'b0;
          ptr_d = ptr_q + 8'd1;
          state_d = MACK;
        end else if (scl_fall) begin
          sh_d = {sh_q[6:0], 1'b0};
          oe_d = ~sh_q[6];
        end
      end
      MACK: begin
        if (scl_rise && sda) state_d = IDLE;
        else if (scl_fall) begin
          state_d = RDATA;
          sh_d = rd;
          oe_d = ~rd[7];
          cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // START (incl. repeated) and STOP override whatever transfer is in progress
    if (start) begin
      state_d = ADDR;
      cnt_d = '0;
      oe_d = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      oe_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sda_q <= 3'b111;
      scl_q <= 3'b111;
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      oe_q <= 1'b0;
      ptr_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      uo_q <= '0;
    end else begin
      sda_q <= {sda_q[1:0], uio_in[0]};
      scl_q <= {scl_q[1:0], uio_in[1]};
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      oe_q <= oe_d;
      ptr_q <= ptr_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      uo_q <= ui_in[0] ? res[15:8] : res[7:0];
    end
  end
endmodule

// File: tb/tb_bsrk_i2c_calc_top.sv
// tb_bsrk_i2c_calc_top: randomized I2C master with reference model and scoreboard
module tb_bsrk_i2c_calc_top;
  localparam int Q = 60;
  logic clk = 0, rst_n = 0, m_sda = 1, m_scl = 1;
  logic [7:0] ui_in = 0, uo_out, uio_out, uio_oe;
  logic sda;
  assign sda = m_sda & ~uio_oe[0];
  always #5 clk = ~clk;
  bsrk_i2c_calc_top dut (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in({6'b0, m_scl, sda}), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  int n_chk = 0, n_fail = 0, slot = 0;
  logic [7:0] bus_q[$], uo_q[$];
  logic [7:0] ma = 0, mb = 0, mptr = 0;
  logic [2:0] mop = 0;
  logic [7:0] wbuf[16];
  function automatic logic [15:0] calc(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    int x = a, y = b, r;
    case (op)
      0: r = x + y;
      1: r = x - y;
      2: r = x * y;
      3: r = x & y;
      4: r = x | y;
      5: r = x ^ y;
      6: r = x * (1 << (y % 16));
      default: r = x / (1 << (y % 8));
    endcase
    return r[15:0];
  endfunction
  function automatic logic [7:0] mreg(logic [2:0] p);
    logic [15:0] r = calc(ma, mb, mop);
    case (p)
      0: return ma;
      1: return mb;
      2: return {5'b0, mop};
      3: return r[7:0];
      4: return r[15:8];
      default: return 8'h00;
    endcase
  endfunction
  task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  initial begin
    logic [7:0] s = 0, e;
    int nb = 0;
    forever begin
      @(posedge m_scl);
      #1;
      if (slot != 0 && bus_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL bus_q: DUT slot with no expectation at %0t", $time);
      end else if (slot == 1) begin
        e = bus_q.pop_front();
        check(e[0] ? "nack" : "ack", {15'b0, sda}, {15'b0, e[0]});
      end else if (slot == 2) begin
        s = {s[6:0], sda};
        nb++;
        if (nb == 8) begin
          nb = 0;
          e = bus_q.pop_front();
          check("rdata", {8'b0, s}, {8'b0, e});
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (uo_q.size() != 0) check("uo_out", {8'b0, uo_out}, {8'b0, uo_q.pop_front()});
  end
  task automatic wbit(logic b);
    m_sda = b; #Q; m_scl = 1; #(2 * Q); m_scl = 0; #Q;
  endtask
  task automatic rbit();
    m_sda = 1; #Q; m_scl = 1; #(2 * Q); m_scl = 0; #Q;
  endtask
  task automatic i2c_start();
    m_sda = 1; #Q; m_scl = 1; #Q; m_sda = 0; #Q; m_scl = 0; #Q;
  endtask
  task automatic i2c_stop();
    m_sda = 0; #Q; m_scl = 1; #Q; m_sda = 1; #(2 * Q);
  endtask
  task automatic wbyte(logic [7:0] d, logic hit);
    bus_q.push_back(hit ? 8'h00 : 8'h01);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    slot = 1;
    rbit();
    slot = 0;
  endtask
  task automatic rbyte(logic ack);
    bus_q.push_back(mreg(mptr[2:0]));
    mptr++;
    slot = 2;
    for (int i = 0; i < 8; i++) rbit();
    slot = 0;
    wbit(~ack);
  endtask
  task automatic wr(logic [6:0] addr, logic [7:0] p, int n);
    logic hit = addr == 7'h42;
    i2c_start();
    wbyte({addr, 1'b0}, hit);
    wbyte(p, hit);
    if (hit) mptr = p;
    for (int i = 0; i < n; i++) begin
      wbyte(wbuf[i], hit);
      if (hit) begin
        if (mptr[2:0] == 0) ma = wbuf[i];
        if (mptr[2:0] == 1) mb = wbuf[i];
        if (mptr[2:0] == 2) mop = wbuf[i][2:0];
        mptr++;
      end
    end
    i2c_stop();
  endtask
  task automatic rd(logic [7:0] p, int n);
    i2c_start();
    wbyte({7'h42, 1'b0}, 1);
    wbyte(p, 1);
    mptr = p;
    i2c_start();
    wbyte({7'h42, 1'b1}, 1);
    for (int i = 0; i < n; i++) rbyte(i != n - 1);
    i2c_stop();
  endtask
  task automatic setabo(logic [7:0] a, logic [7:0] b, logic [7:0] op);
    wbuf[0] = a; wbuf[1] = b; wbuf[2] = op;
    wr(7'h42, 8'h00, 3);
  endtask
  task automatic uochk(logic sel);
    logic [15:0] r;
    ui_in[0] = sel;
    repeat (3) @(posedge clk);
    r = calc(ma, mb, mop);
    uo_q.push_back(sel ? r[15:8] : r[7:0]);
    @(negedge clk);
    @(posedge clk);
  endtask
  initial begin
    repeat (5) @(posedge clk);
    #1;
    check("oe_reset", {8'b0, uio_oe}, 16'h0);
    check("uio_out", {8'b0, uio_out}, 16'h0);
    uochk(0);
    @(negedge clk) rst_n = 1;
    #(4 * Q);
    setabo(8'h12, 8'h34, 8'h00);
    rd(8'h03, 2);
    uochk(0);
    setabo(8'hFF, 8'hFF, 8'h02);
    rd(8'h03, 2);
    uochk(1);
    setabo(8'h01, 8'h02, 8'h01);
    rd(8'h03, 2);
    setabo(8'h81, 8'h04, 8'h06);
    rd(8'h03, 2);
    wbuf[0] = 8'h99;
    wr(7'h43, 8'h00, 1);
    rd(8'h00, 8);
    for (int i = 0; i < 9; i++) wbuf[i] = 8'hA0 + 8'(i);
    wr(7'h42, 8'h06, 9);
    rd(8'h00, 8);
    for (int it = 0; it < 10; it++) begin
      setabo(8'($urandom), 8'($urandom), 8'($urandom));
      rd(8'h03, 2);
      uochk(1'($urandom));
      if (it % 4 == 3) begin
        int n = $urandom_range(1, 10);
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
        wr($urandom_range(0, 3) == 0 ? 7'h43 : 7'h42, 8'($urandom), n);
        rd(8'($urandom), $urandom_range(2, 8));
      end
    end
    setabo(8'h00, 8'h55, 8'h05);
    uochk(0);
    i2c_start();
    wbyte({7'h42, 1'b0}, 1);
    wbyte(8'h00, 1);
    i2c_start();
    wbyte({7'h42, 1'b1}, 1);
    check("oe_read_drive", {15'b0, uio_oe[0]}, 16'h1);
    @(negedge clk) rst_n = 0;
    @(posedge clk);
    #1;
    check("oe_after_rst", {8'b0, uio_oe}, 16'h0);
    ma = 0; mb = 0; mop = 0;
    repeat (3) @(posedge clk);
    uochk(0);
    @(negedge clk) rst_n = 1;
    i2c_stop();
    uochk(1);
    rd(8'h00, 5);
    #1000;
    check("sb_drained", 16'(bus_q.size() + uo_q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
